z_1_rtc_spi_ctrl: RTL and testbench
===================================

// Module: z_1_rtc_spi_ctrl
// PURPOSE
//  SPI-mode-0 slave command sequencer for the z_1 RTC; sits between pads pin1..pin4 and the timekeeping counter.
//  Oversamples sclk/mosi/cs_n in the clk domain and decodes an 8-bit command.
//  Then either streams a 64-bit time snapshot out on miso, or collects 64 bits and issues a counter load.
//  Frame = 8 cmd bits + 64 payload bits = 72 sclk rising edges, MSB first.
// PARAMETERS
//  SYNC_STAGES  2      flops per input synchronizer (>=2)
//  DATA_W       64     payload / time width
//  CMD_RD       8'h02  read-time command
//  CMD_WR       8'h03  write-time command
// PORTS
//  clk         in   1       system clock; must be >=8x sclk frequency
//  rst         in   1       asynchronous, active-high reset
//  sclk_i      in   1       SPI clock pad (async)
//  mosi_i      in   1       SPI data in pad (async)
//  cs_n_i      in   1       SPI select, active low (async; may be tied 0)
//  miso_o      out  1       SPI data out
//  time_i      in   DATA_W  live RTC count
//  snap_o      out  1       1-cycle pulse: time_i captured
//  load_o      out  1       1-cycle pulse: load_val_o valid, counter must load
//  load_val_o  out  DATA_W  value to load (held until next load)
//  busy_o      out  1       high while state != CMD or bit_cnt != 0
//  cmd_err_o   out  1       1-cycle pulse: unknown command decoded
// BEHAVIOUR
//  Reset: all outputs 0, state=CMD, bit_cnt=0, shift regs 0.
//  Inputs pass SYNC_STAGES flops.
//  rise/fall = one-cycle strobes from the synced sclk vs its previous value; 3-cycle pad-to-strobe latency at default.
//  cs_n synced high: state->CMD, bit_cnt->0, miso_o->0, pending write discarded (no load_o).
//  Edges are ignored while cs_n is high.
//  On rise: shift mosi into rx_sr, bit_cnt++ (7 bits, 0..71).
//  States:
//   CMD: on the rise with bit_cnt==7 (8th bit), decode {rx_sr[6:0],mosi}.
//     CMD_RD -> tx_sr<=time_i, snap_o pulse, READ.
//     CMD_WR -> WRITE.
//     else   -> cmd_err_o pulse, SKIP.
//   READ: on each fall drive miso_o<=tx_sr[63], then tx_sr<<=1.
//     The first fall after the command drives bit 63, so the master samples bit 63-k on rise 9+k.
//     A snapshot is immune to later time_i changes.
//   WRITE: on rise shift mosi into wr_sr. On the 72nd rise: load_val_o<={wr_sr[62:0],mosi}, load_o pulse next cycle.
//   SKIP: count edges, miso_o=0, no side effects.
//   On the 72nd rise of any state -> CMD, bit_cnt->0.
//   miso_o returns to 0 on the next fall, so back-to-back frames need no cs_n toggle.
//  Simultaneous rise and cs_n deassert in one cycle: cs_n wins, the edge is dropped.
//  rst mid-frame: immediate (async) return to reset values; no load_o.
// STRUCTURE
//  z_1_rtc_pkg: CMD_RD/CMD_WR constants, FRAME_BITS=72, CMD_BITS=8, state encoding {CMD,READ,WRITE,SKIP}.
//  Sub-module z_1_rtc_sync: parameterized SYNC_STAGES synchronizer with async reset to 0 (cs_n resets to 1).
//  Instantiated 3x: sclk, mosi, cs_n.
//  Top body: edge detect, bit counter, 4-state FSM, rx/tx/wr shift registers.
// TESTING
//  clk period 2, sclk half-period 29, cs_n=0 throughout unless stated.
//  1 Read: time_i=64'h0123_4567_89AB_CDEF, send 0x02 + 64 dummy bits.
//    -> snap_o once after rise 8; miso bits sampled on rises 9..72 = 0x0123456789ABCDEF.
//  2 Snapshot hold: as 1, but time_i increments every 3 clk.
//    -> miso stream equals time_i at the snap_o cycle.
//  3 Back-to-back: two 0x02 frames with no gap -> two snap_o pulses, both streams correct, busy_o low between.
//  4 Write: 0x03 + 64'hDEAD_BEEF_0000_0001 -> exactly one load_o, load_val_o=64'hDEADBEEF00000001, miso stays 0.
//  5 Bad cmd: 0x7F + 64 bits -> one cmd_err_o, no snap_o/load_o, miso 0; following 0x02 frame decodes correctly.
//  6 Abort: cs_n high after 40 bits of a write, then low, then a full 0x02 frame -> no load_o, read correct.
//    Assert rst at rise 30 of a read -> miso_o=0, busy_o=0 immediately.

Source files
------------

// File: rtl/z_1_rtc_pkg.sv
// Shared constants and state encoding for the z_1 RTC SPI command sequencer.
package z_1_rtc_pkg;

    localparam int          CMD_BITS   = 8;
    localparam int          DEF_DATA_W = 64;
    localparam int          FRAME_BITS = CMD_BITS + DEF_DATA_W;
    localparam int          CNT_W      = 7;
    localparam logic [7:0]  CMD_RD     = 8'h02;
    localparam logic [7:0]  CMD_WR     = 8'h03;

    typedef enum logic [1:0] {
        ST_CMD,
        ST_READ,
        ST_WRITE,
        ST_SKIP
    } state_t;

endpackage

// File: rtl/z_1_rtc_sync.sv
// Multi-flop synchronizer for one asynchronous pad signal into the clk domain.
module z_1_rtc_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Shift the pad value through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= {STAGES{RST_VAL}};
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's old value.
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/z_1_rtc_spi_ctrl.sv
// SPI mode-0 slave: decodes an 8-bit command, then streams a time snapshot
// out on miso or collects a 64-bit value and requests a counter load.
module z_1_rtc_spi_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter int         DATA_W      = z_1_rtc_pkg::DEF_DATA_W,
    parameter logic [7:0] CMD_RD      = z_1_rtc_pkg::CMD_RD,
    parameter logic [7:0] CMD_WR      = z_1_rtc_pkg::CMD_WR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_i,
    input  logic              mosi_i,
    input  logic              cs_n_i,
    output logic              miso_o,
    input  logic [DATA_W-1:0] time_i,
    output logic              snap_o,
    output logic              load_o,
    output logic [DATA_W-1:0] load_val_o,
    output logic              busy_o,
    output logic              cmd_err_o
);

    import z_1_rtc_pkg::*;

    localparam int LAST_BIT = CMD_BITS + DATA_W - 1;

    logic              sclk_s, mosi_s, cs_n_s, sclk_q;
    logic              rise, fall;
    logic [CNT_W-1:0]  bit_cnt;
    logic              last_bit, cmd_bit;
    logic [6:0]        rx_sr;
    logic [7:0]        cmd_word;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-2:0] wr_sr;
    state_t            state, state_nxt;
    logic              snap_d, err_d, load_d;

    z_1_rtc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk_i), .q(sclk_s)
    );
    z_1_rtc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi_i), .q(mosi_s)
    );
    z_1_rtc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .rst(rst), .d(cs_n_i), .q(cs_n_s)
    );

    // Edges are only meaningful while the slave is selected.
    assign rise     = sclk_s & ~sclk_q & ~cs_n_s;
    assign fall     = ~sclk_s & sclk_q & ~cs_n_s;
    assign last_bit = (bit_cnt == CNT_W'(LAST_BIT));
    assign cmd_bit  = (bit_cnt == CNT_W'(CMD_BITS - 1));
    assign cmd_word = {rx_sr, mosi_s};
    assign busy_o   = (state != ST_CMD) || (bit_cnt != '0);

    // Remember the previous synced sclk for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sclk_q <= 1'b0;
        else     sclk_q <= sclk_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_CMD;
        else     state <= state_nxt;
    end

    // Next-state decode and single-cycle event requests.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal (no latches).
        state_nxt = state;
        snap_d    = 1'b0;
        err_d     = 1'b0;
        load_d    = 1'b0;
        if (cs_n_s) begin
            state_nxt = ST_CMD;
        end else if (rise) begin
            if (last_bit) begin
                state_nxt = ST_CMD;
                load_d    = (state == ST_WRITE);
            end else if (state == ST_CMD && cmd_bit) begin
                case (cmd_word)
                    CMD_RD: begin
                        state_nxt = ST_READ;
                        snap_d    = 1'b1;
                    end
                    CMD_WR:  state_nxt = ST_WRITE;
                    default: begin
                        state_nxt = ST_SKIP;
                        err_d     = 1'b1;
                    end
                endcase
            end
        end
    end

    // Bit counter, shift registers, miso driver and output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shift registers are ordinary flops, so they are reset
            // too; miso_o and load_val_o are then defined straight out of reset.
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            wr_sr      <= '0;
            miso_o     <= 1'b0;
            snap_o     <= 1'b0;
            load_o     <= 1'b0;
            cmd_err_o  <= 1'b0;
            load_val_o <= '0;
        end else begin
            snap_o    <= snap_d;
            cmd_err_o <= err_d;
            load_o    <= load_d;
            if (load_d) load_val_o <= {wr_sr, mosi_s};
            if (cs_n_s) begin
                bit_cnt <= '0;
                miso_o  <= 1'b0;
            end else begin
                if (rise) begin
                    rx_sr   <= {rx_sr[5:0], mosi_s};
                    bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
                    if (state == ST_WRITE) wr_sr <= {wr_sr[DATA_W-3:0], mosi_s};
                end
                if (snap_d) tx_sr <= time_i;
                if (fall) begin
                    if (state == ST_READ) begin
                        miso_o <= tx_sr[DATA_W-1];
                        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                    end else begin
                        miso_o <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_z_1_rtc_spi_ctrl.sv
// Self-checking bench for z_1_rtc_spi_ctrl: table of full frames plus
// hand-written sequences for snapshot hold, back-to-back, abort and reset.
module tb_z_1_rtc_spi_ctrl;

    logic        clk = 1'b0;
    bit          clk_run = 1'b1;
    logic        rst, sclk_i, mosi_i, cs_n_i;
    logic [63:0] time_i;
    logic        miso_o, snap_o, load_o, busy_o, cmd_err_o;
    logic [63:0] load_val_o;

    int errors = 0;
    int checks = 0;

    // Event monitor counters (written only by the monitor process).
    int          snap_cnt = 0, load_cnt = 0, err_cnt = 0, miso_hi = 0;
    logic [63:0] last_time = '0, snap_time = '0;
    bit          inc_en = 1'b0;

    z_1_rtc_spi_ctrl dut (
        .clk(clk), .rst(rst), .sclk_i(sclk_i), .mosi_i(mosi_i), .cs_n_i(cs_n_i),
        .miso_o(miso_o), .time_i(time_i), .snap_o(snap_o), .load_o(load_o),
        .load_val_o(load_val_o), .busy_o(busy_o), .cmd_err_o(cmd_err_o)
    );

    always #1 clk = clk_run ? ~clk : clk;

    // Value of time_i seen by the DUT at each rising edge.
    always @(posedge clk) last_time = time_i;

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (snap_o) begin
            snap_cnt++;
            snap_time = last_time;
        end
        if (load_o)    load_cnt++;
        if (cmd_err_o) err_cnt++;
        if (miso_o)    miso_hi++;
    end

    // Free-running time counter for the snapshot-hold sequence.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            if (inc_en) begin
                div++;
                if (div == 3) begin
                    time_i = time_i + 64'd1;
                    div    = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Send n bits of a 72-bit frame MSB first; miso is sampled on rises 9..n.
    task automatic send_bits(input logic [71:0] data, input int n, output logic [63:0] word);
        word = '0;
        for (int i = 0; i < n; i++) begin
            mosi_i = data[71-i];
            #29;
            sclk_i = 1'b1;
            if (i >= 8) word[71-i] = miso_o;
            #29;
            sclk_i = 1'b0;
        end
    endtask

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [63:0] payload;
        logic [63:0] tval;
        int          exp_snap;
        int          exp_load;
        int          exp_err;
        logic [63:0] exp_miso;
        logic [63:0] exp_lval;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [63:0] w, w2;
        int s0, l0, e0, m0;

        vecs[0] = '{"rd_a",     8'h02, 64'h0,                    64'h0123_4567_89AB_CDEF, 1, 0, 0, 64'h0123_4567_89AB_CDEF, 64'h0};
        vecs[1] = '{"rd_b",     8'h02, 64'hFFFF_FFFF_FFFF_FFFF,  64'hA5A5_0F0F_F0F0_5A5A, 1, 0, 0, 64'hA5A5_0F0F_F0F0_5A5A, 64'h0};
        vecs[2] = '{"wr_a",     8'h03, 64'hDEAD_BEEF_0000_0001,  64'h1111_2222_3333_4444, 0, 1, 0, 64'h0, 64'hDEAD_BEEF_0000_0001};
        vecs[3] = '{"bad_7f",   8'h7F, 64'h0123_4567_89AB_CDEF,  64'h5555_5555_5555_5555, 0, 0, 1, 64'h0, 64'h0};
        vecs[4] = '{"rd_c",     8'h02, 64'h0,                    64'h8000_0000_0000_0001, 1, 0, 0, 64'h8000_0000_0000_0001, 64'h0};
        vecs[5] = '{"wr_b",     8'h03, 64'h8000_0000_0000_0080,  64'h0,                   0, 1, 0, 64'h0, 64'h8000_0000_0000_0080};
        vecs[6] = '{"bad_01",   8'h01, 64'hFFFF_FFFF_FFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 64'h0, 64'h0};

        rst    = 1'b1;
        sclk_i = 1'b0;
        mosi_i = 1'b0;
        cs_n_i = 1'b0;
        time_i = '0;
        repeat (3) @(negedge clk);
        check("rst.miso",     64'(miso_o),    64'h0);
        check("rst.busy",     64'(busy_o),    64'h0);
        check("rst.snap",     64'(snap_o),    64'h0);
        check("rst.load",     64'(load_o),    64'h0);
        check("rst.cmd_err",  64'(cmd_err_o), 64'h0);
        check("rst.load_val", load_val_o,     64'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven full frames.
        for (int k = 0; k < 7; k++) begin
            time_i = vecs[k].tval;
            s0 = snap_cnt; l0 = load_cnt; e0 = err_cnt; m0 = miso_hi;
            send_bits({vecs[k].cmd, vecs[k].payload}, 72, w);
            repeat (4) @(negedge clk);
            check($sformatf("%s.snap", vecs[k].name), 64'(snap_cnt - s0), 64'(vecs[k].exp_snap));
            check($sformatf("%s.load", vecs[k].name), 64'(load_cnt - l0), 64'(vecs[k].exp_load));
            check($sformatf("%s.err",  vecs[k].name), 64'(err_cnt - e0),  64'(vecs[k].exp_err));
            check($sformatf("%s.miso", vecs[k].name), w, vecs[k].exp_miso);
            check($sformatf("%s.busy", vecs[k].name), 64'(busy_o), 64'h0);
            if (vecs[k].exp_snap == 0)
                check($sformatf("%s.miso_quiet", vecs[k].name), 64'(miso_hi - m0), 64'h0);
            if (vecs[k].exp_load != 0)
                check($sformatf("%s.load_val", vecs[k].name), load_val_o, vecs[k].exp_lval);
        end

        // Snapshot hold: time_i keeps moving during the read.
        time_i = 64'h0000_0000_0000_1000;
        s0 = snap_cnt;
        inc_en = 1'b1;
        send_bits({8'h02, 64'h0}, 72, w);
        inc_en = 1'b0;
        repeat (4) @(negedge clk);
        check("hold.snap", 64'(snap_cnt - s0), 64'h1);
        check("hold.miso", w, snap_time);

        // Back-to-back reads with no cs_n toggle.
        s0 = snap_cnt;
        time_i = 64'hCAFE_F00D_1234_5678;
        send_bits({8'h02, 64'h0}, 72, w);
        @(negedge clk);
        check("b2b.busy_gap", 64'(busy_o), 64'h0);
        time_i = 64'h0F1E_2D3C_4B5A_6978;
        send_bits({8'h02, 64'h0}, 72, w2);
        repeat (4) @(negedge clk);
        check("b2b.snap",  64'(snap_cnt - s0), 64'h2);
        check("b2b.miso1", w,  64'hCAFE_F00D_1234_5678);
        check("b2b.miso2", w2, 64'h0F1E_2D3C_4B5A_6978);

        // Abort a write after 40 bits, then a full read.
        l0 = load_cnt; s0 = snap_cnt;
        send_bits({8'h03, 64'hDEAD_BEEF_0000_0001}, 40, w);
        cs_n_i = 1'b1;
        #40;
        check("abort.busy_cs_high", 64'(busy_o), 64'h0);
        cs_n_i = 1'b0;
        #10;
        time_i = 64'h7654_3210_FEDC_BA98;
        send_bits({8'h02, 64'h0}, 72, w);
        repeat (4) @(negedge clk);
        check("abort.load", 64'(load_cnt - l0), 64'h0);
        check("abort.snap", 64'(snap_cnt - s0), 64'h1);
        check("abort.miso", w, 64'h7654_3210_FEDC_BA98);

        // Reset at rise 30 of a read, with the clock stopped so only an
        // asynchronous reset can clear the outputs.
        l0 = load_cnt;
        time_i = 64'hFFFF_FFFF_FFFF_FFFF;
        send_bits({8'h02, 64'h0}, 29, w);
        mosi_i = 1'b0;
        #29;
        sclk_i = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_mid.busy_before", 64'(busy_o), 64'h1);
        check("rst_mid.miso_before", 64'(miso_o), 64'h1);
        clk_run = 1'b0;
        #1;
        rst = 1'b1;
        #3;
        check("rst_mid.miso", 64'(miso_o), 64'h0);
        check("rst_mid.busy", 64'(busy_o), 64'h0);
        clk_run = 1'b1;
        sclk_i  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        time_i = 64'h0123_4567_89AB_CDEF;
        send_bits({8'h02, 64'h0}, 72, w);
        repeat (4) @(negedge clk);
        check("rst_mid.load", 64'(load_cnt - l0), 64'h0);
        check("rst_mid.recover", w, 64'h0123_4567_89AB_CDEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
